// File: rtl/riscv_pkg.sv
// Shared load/store definitions: LSU FSM states, access-size codes and
// funct3 legality/alignment helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        MEM_B  = F3_LB,
        MEM_H  = F3_LH,
        MEM_W  = F3_LW,
        MEM_BU = F3_LBU,
        MEM_HU = F3_LHU
    } mem_size_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Byte accesses can never be misaligned; halfwords need an even address.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store steering with byte enables, and load
// byte/halfword extraction with sign or zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  off,
    input  logic [31:0] st_in,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    mem_size_e   size;
    logic [3:0]  be_base;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size = mem_size_e'(f3);

    always_comb begin
        be_base = 4'b1111;
        case (size)
            MEM_B, MEM_BU: be_base = 4'b0001;
            MEM_H, MEM_HU: be_base = 4'b0011;
            default:       be_base = 4'b1111;
        endcase
    end

    // Word accesses are always aligned, so shifting their full mask is harmless.
    assign be = be_base << off;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_data[8*gi +: 8] = (f3[1:0] == 2'b00) ? st_in[7:0] :
                                        (f3[1:0] == 2'b01) ? st_in[8*(gi%2) +: 8] :
                                                             st_in[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = ld_raw[8*off +: 8];
    assign half_sel = ld_raw[16*off[1] +: 16];

    always_comb begin
        ld_data = ld_raw;
        case (size)
            MEM_B:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_BU:  ld_data = {24'd0, byte_sel};
            MEM_HU:  ld_data = {16'd0, half_sel};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one access from decode, runs a valid/grant/rvalid
// memory transaction with timeout, and returns extended load data for writeback.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_bus
);

    localparam int CW = $clog2(TIMEOUT);

    lsu_state_e  state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic        we_reg;
    logic [2:0]  f3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [4:0]  rd_reg;
    logic [31:0] rdata_reg;
    logic        err_misalign_reg;
    logic        err_bus_reg;

    logic        accept, misalign, illegal, timeout_hit, cnt_expired, in_req;
    logic [3:0]  be;
    logic [31:0] st_data, ld_data;

    lsu_align u_align (
        .f3      (f3_reg),
        .off     (addr_reg[1:0]),
        .st_in   (wdata_reg),
        .ld_raw  (mem_rdata),
        .be      (be),
        .st_data (st_data),
        .ld_data (ld_data)
    );

    assign cnt_expired = (cnt_reg == CW'(TIMEOUT - 1));

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        misalign    = 1'b0;
        illegal     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (!f3_legal(req_funct3)) begin
                        illegal = 1'b1;
                    end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                        misalign = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next = mem_rvalid ? DONE : WAIT;
                end else if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                end else if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            we_reg           <= 1'b0;
            f3_reg           <= 3'b000;
            addr_reg         <= 32'd0;
            wdata_reg        <= 32'd0;
            rd_reg           <= 5'd0;
            rdata_reg        <= 32'd0;
            err_misalign_reg <= 1'b0;
            err_bus_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            err_misalign_reg <= misalign;
            err_bus_reg      <= illegal | timeout_hit;
            // Counter restarts on every state change so REQ and WAIT each get a full budget.
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (state_reg == REQ || state_reg == WAIT) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (accept) begin
                we_reg    <= req_we;
                f3_reg    <= req_funct3;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                rd_reg    <= req_rd;
            end
            if (state_next == DONE && !we_reg) begin
                rdata_reg <= ld_data;
            end
        end
    end

    assign in_req       = (state_reg == REQ);
    assign stall        = accept || in_req || (state_reg == WAIT);
    assign mem_req      = in_req;
    assign mem_we       = in_req && we_reg;
    assign mem_addr     = in_req ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem_be       = in_req ? be : 4'b0000;
    assign mem_wdata    = (in_req && we_reg) ? st_data : 32'd0;
    assign wb_valid     = (state_reg == DONE) && !we_reg && (rd_reg != 5'd0);
    assign wb_rd        = wb_valid ? rd_reg : 5'd0;
    assign wb_data      = wb_valid ? rdata_reg : 32'd0;
    assign err_misalign = err_misalign_reg;
    assign err_bus      = err_bus_reg;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit that sits directly downstream of the decode/ALU stage. It takes one L-type or S-type access (computed address, store data, funct3) and turns it into a word-aligned valid/grant/rvalid transaction on the data-memory port, with byte enables. It returns sign- or zero-extended load data plus its destination register for regfile writeback. It holds the core via a stall output while a transaction is in flight.

Parameters:
- TIMEOUT, 16, cycles waiting for mem_gnt or mem_rvalid before the access is aborted with a bus error (must be >= 2).

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  access request from decode; sampled only in IDLE.
- req_we  in  1  1 = store (S-type), 0 = load (L-type).
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- req_addr  in  32  effective byte address (rs1 + imm).
- req_wdata  in  32  rs2 value, right-aligned.
- req_rd  in  5  load destination register.
- stall  out  1  1 while an accepted access is not complete.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address {req_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data / write ack valid.
- mem_rdata  in  32  raw read word.
- wb_valid  out  1  one-cycle pulse: load data ready for regfile.
- wb_rd  out  5  destination register for wb_data.
- wb_data  out  32  extended load result.
- err_misalign  out  1  one-cycle pulse: misaligned access rejected.
- err_bus  out  1  one-cycle pulse: timeout or illegal funct3.

Behaviour:
- Reset (reset=0, async):
  - FSM enters IDLE.
  - All outputs are 0. Any in-flight transaction is dropped with no wb_valid.
  - Request registers are cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If req_valid and the access is legal and aligned: latch the request, drive stall=1 combinationally in that same cycle, and go to REQ.
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): err_misalign=1 for one cycle, stay in IDLE, no memory request, stall=0.
  - Illegal funct3: err_bus=1 for one cycle, stay in IDLE.
- REQ:
  - mem_req=1 with latched mem_we, mem_addr, mem_be, mem_wdata.
  - These outputs are held stable until mem_gnt.
  - On mem_gnt, go to WAIT. If mem_rvalid is also high in the same cycle, go straight to DONE.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, go to DONE; loads capture the extended data.
- DONE:
  - For loads: wb_valid=1 with wb_rd and wb_data.
  - For stores: no wb_valid.
  - stall=0 in DONE; return to IDLE next cycle.
  - Latency for a zero-wait memory (gnt in REQ, rvalid the next cycle): accept→DONE = 3 cycles.
- Timeout:
  - A counter is reset on each state entry and counts in REQ and WAIT.
  - When it reaches TIMEOUT: err_bus pulses, stall drops, and the FSM goes to IDLE. No wb_valid is produced.
  - mem_rvalid arriving after the abort is ignored.
- Byte enables and store data, by size (off = addr[1:0]):
  - B: be = 0001<<off; wdata byte replicated in all 4 lanes.
  - H: be = 0011<<off; halfword replicated in both halves.
  - W: be = 1111.
  - Loads drive the same be pattern.
- Load extraction:
  - Select the byte/halfword at off.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Register x0:
  - A load with rd=0 still performs the memory read.
  - wb_valid is suppressed (0) when rd=0.
- req_valid while stall=1 is ignored; the upstream stage holds its request.

Decomposition:
- riscv_pkg additions:
  - lsu_state_e enum {IDLE, REQ, WAIT, DONE}.
  - mem_size_e enum for the funct3 codes.
  - Constants F3_LB..F3_LHU.
- Sub-module lsu_align (combinational):
  - Store lane steering and byte-enable generation.
  - Load extraction and extension.
- The FSM, request latches and timeout counter stay in lsu_ctrl.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, memory grants immediately → mem_addr=0x100, be=1111, wdata=0xDEADBEEF, stall high 3 cycles, no wb_valid.
- LB addr=0x203, rd=5, mem_rdata=0x80000000 → be=1000, wb_valid, wb_rd=5, wb_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH addr=0x102, wdata=0x0000ABCD → be=1100, wdata=0xABCDABCD. LH addr=0x101 → err_misalign pulse, mem_req never asserted, stall=0.
- LW with gnt delayed 5 cycles → mem_req, mem_addr and mem_be stable across all 5 cycles; wb_data equals mem_rdata. LW with no rvalid and TIMEOUT=16 → err_bus after 16 WAIT cycles, no wb_valid.
- reset driven to 0 while in WAIT → all outputs 0 immediately; a later rvalid does not produce wb_valid; the next LW completes normally.
- LW rd=0 → memory read occurs, wb_valid stays 0. funct3=011 → err_bus pulse, no memory request.
